// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: ALU select codes,
// R-type funct codes and the sequencer state encoding.
package alu_ctrl_pkg;

  // ALU select codes
  localparam logic [2:0] GOUT_AND  = 3'b000;
  localparam logic [2:0] GOUT_OR   = 3'b001;
  localparam logic [2:0] GOUT_ADD  = 3'b010;
  localparam logic [2:0] GOUT_SLL  = 3'b011;
  localparam logic [2:0] GOUT_NORI = 3'b100;
  localparam logic [2:0] GOUT_SUB  = 3'b110;
  localparam logic [2:0] GOUT_SLT  = 3'b111;

  // main-control aluop codes
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_NORI = 2'b11;

  // full-width R-type funct codes; legacy 4-bit mode uses the low nibble
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_BALRZ = 6'b010110;

  // sequencer states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Handshake bus between decode/control (master) and the ALU control
// sequencer (slave).
interface alu_ctrl_seq_if #(
  parameter int FW = 6,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    aluop;
  logic [FW-1:0] funct;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    gout;
  logic          balrz_link;
  logic          balrz_branch;
  logic          last;
  logic          illegal;
  logic [CW-1:0] illegal_cnt;

  modport master (
    output in_valid, aluop, funct, out_ready,
    input  in_ready, out_valid, gout, balrz_link, balrz_branch, last,
           illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, aluop, funct, out_ready,
    output in_ready, out_valid, gout, balrz_link, balrz_branch, last,
           illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of (aluop, funct) into an ALU select, a balrz
// marker and an illegal-funct flag. Only the low FW bits of each funct
// code are compared, so FW=4 gives the legacy nibble table.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int         FW           = 6,
  parameter logic [5:0] BALRZ_FUNCT  = F_BALRZ,
  parameter logic [2:0] ILLEGAL_GOUT = GOUT_ADD
) (
  input  logic [1:0]    aluop,
  input  logic [FW-1:0] funct,
  output logic [2:0]    gout,
  output logic          is_balrz,
  output logic          illegal
);

  localparam logic [FW-1:0] C_ADD   = FW'(F_ADD);
  localparam logic [FW-1:0] C_SUB   = FW'(F_SUB);
  localparam logic [FW-1:0] C_AND   = FW'(F_AND);
  localparam logic [FW-1:0] C_OR    = FW'(F_OR);
  localparam logic [FW-1:0] C_SLT   = FW'(F_SLT);
  localparam logic [FW-1:0] C_SLL   = FW'(F_SLL);
  localparam logic [FW-1:0] C_BALRZ = FW'(BALRZ_FUNCT);

  // priority chain: in legacy mode sll aliases add and add wins
  always_comb begin
    gout     = GOUT_ADD;
    is_balrz = 1'b0;
    illegal  = 1'b0;
    case (aluop)
      ALUOP_ADD:  gout = GOUT_ADD;
      ALUOP_SUB:  gout = GOUT_SUB;
      ALUOP_NORI: gout = GOUT_NORI;
      default: begin
        if      (funct == C_ADD)   gout = GOUT_ADD;
        else if (funct == C_SUB)   gout = GOUT_SUB;
        else if (funct == C_AND)   gout = GOUT_AND;
        else if (funct == C_OR)    gout = GOUT_OR;
        else if (funct == C_SLT)   gout = GOUT_SLT;
        else if (funct == C_SLL)   gout = GOUT_SLL;
        else if (funct == C_BALRZ) begin
          gout     = GOUT_ADD;
          is_balrz = 1'b1;
        end else begin
          gout    = ILLEGAL_GOUT;
          illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control unit. One output register holds the
// current beat; balrz expands into a link beat followed by a zero-test
// branch beat. Illegal R-type functs are flagged and counted.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int         FW           = 6,
  parameter logic [5:0] BALRZ_FUNCT  = F_BALRZ,
  parameter logic [2:0] ILLEGAL_GOUT = GOUT_ADD,
  parameter int         CW           = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_ctrl_seq_if.slave bus
);

  logic [1:0]    state;
  logic [2:0]    gout_q;
  logic          link_q, branch_q, last_q, illegal_q;
  logic [CW-1:0] cnt_q;

  logic [2:0] dec_gout;
  logic       dec_balrz, dec_illegal;
  logic       accept, consume;

  alu_ctrl_dec #(
    .FW           (FW),
    .BALRZ_FUNCT  (BALRZ_FUNCT),
    .ILLEGAL_GOUT (ILLEGAL_GOUT)
  ) u_dec (
    .aluop    (bus.aluop),
    .funct    (bus.funct),
    .gout     (dec_gout),
    .is_balrz (dec_balrz),
    .illegal  (dec_illegal)
  );

  // ready when empty, or when the held final beat leaves this cycle
  always_comb begin
    bus.in_ready = (state == ST_EMPTY) || ((state == ST_HOLD) && bus.out_ready);
  end

  assign bus.out_valid    = (state != ST_EMPTY);
  assign accept           = bus.in_valid && bus.in_ready;
  assign consume          = bus.out_valid && bus.out_ready;
  assign bus.gout         = gout_q;
  assign bus.balrz_link   = link_q;
  assign bus.balrz_branch = branch_q;
  assign bus.last         = last_q;
  assign bus.illegal      = illegal_q;
  assign bus.illegal_cnt  = cnt_q;

  // sequencer FSM and output beat register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      gout_q    <= GOUT_ADD;
      link_q    <= 1'b0;
      branch_q  <= 1'b0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state == ST_FIRST) begin
      // second balrz micro-op once the link beat is taken
      if (consume) begin
        state    <= ST_HOLD;
        gout_q   <= GOUT_SUB;
        link_q   <= 1'b0;
        branch_q <= 1'b1;
        last_q   <= 1'b1;
      end
    end else if (accept) begin
      gout_q    <= dec_gout;
      branch_q  <= 1'b0;
      illegal_q <= dec_illegal;
      if (dec_balrz) begin
        state  <= ST_FIRST;
        link_q <= 1'b1;
        last_q <= 1'b0;
      end else begin
        state  <= ST_HOLD;
        link_q <= 1'b0;
        last_q <= 1'b1;
      end
    end else if (consume) begin
      state     <= ST_EMPTY;
      link_q    <= 1'b0;
      branch_q  <= 1'b0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  // saturating count of accepted illegal instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (accept && dec_illegal && (cnt_q != {CW{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench: a queue of pending output beats models the unit.
// Each accepted instruction appends its beats; each consumed beat is
// popped. Ready/valid expectations follow from the queue occupancy.
module tb_alu_ctrl_seq;
  localparam int FW = 6;
  localparam int CW = 2;

  typedef struct {
    logic [2:0] g;
    logic       lnk;
    logic       br;
    logic       lst;
    logic       ill;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.FW(FW), .CW(CW)) bus ();

  alu_ctrl_seq #(
    .FW           (FW),
    .BALRZ_FUNCT  (6'b010110),
    .ILLEGAL_GOUT (3'b010),
    .CW           (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  beat_t q[$];
  int    cnt_m = 0;
  int    n_assert = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected beats of one instruction, straight from the opcode table
  task automatic expand(input logic [1:0] op, input logic [5:0] f);
    beat_t b;
    b = '{g: 3'b010, lnk: 1'b0, br: 1'b0, lst: 1'b1, ill: 1'b0};
    if (op == 2'b00) b.g = 3'b010;
    else if (op == 2'b01) b.g = 3'b110;
    else if (op == 2'b11) b.g = 3'b100;
    else begin
      case (f)
        6'd32: b.g = 3'b010;
        6'd34: b.g = 3'b110;
        6'd36: b.g = 3'b000;
        6'd37: b.g = 3'b001;
        6'd42: b.g = 3'b111;
        6'd0:  b.g = 3'b011;
        6'd22: begin
          q.push_back('{g: 3'b010, lnk: 1'b1, br: 1'b0, lst: 1'b0, ill: 1'b0});
          b = '{g: 3'b110, lnk: 1'b0, br: 1'b1, lst: 1'b1, ill: 1'b0};
        end
        default: begin
          b.ill = 1'b1;
          if (cnt_m < (1 << CW) - 1) cnt_m++;
        end
      endcase
    end
    q.push_back(b);
  endtask

  // one clock: inputs already driven; check, then advance the model
  task automatic cyc(input string tag);
    logic exp_rdy, exp_vld, acc, con;
    #1;
    exp_vld = (q.size() > 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_vld));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    chk({tag, ".cnt"}, 32'(bus.illegal_cnt), 32'(cnt_m));
    if (exp_vld) begin
      chk({tag, ".gout"}, 32'(bus.gout), 32'(q[0].g));
      chk({tag, ".link"}, 32'(bus.balrz_link), 32'(q[0].lnk));
      chk({tag, ".branch"}, 32'(bus.balrz_branch), 32'(q[0].br));
      chk({tag, ".last"}, 32'(bus.last), 32'(q[0].lst));
      chk({tag, ".illegal"}, 32'(bus.illegal), 32'(q[0].ill));
    end
    acc = bus.in_valid && exp_rdy;
    con = exp_vld && bus.out_ready;
    @(posedge clk);
    if (con) void'(q.pop_front());
    if (acc) expand(bus.aluop, bus.funct);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic rdy);
    bus.in_valid  = v;
    bus.aluop     = op;
    bus.funct     = f;
    bus.out_ready = rdy;
  endtask

  initial begin
    logic [5:0] rtab [7];
    rtab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd22};
    drive(1'b0, 2'b00, 6'd0, 1'b1);
    repeat (2) @(negedge clk);
    // reset state
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.gout", 32'(bus.gout), 32'd2);
    chk("rst.last", 32'(bus.last), 32'd0);
    chk("rst.illegal", 32'(bus.illegal), 32'd0);
    chk("rst.cnt", 32'(bus.illegal_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // non-R-type ops back to back
    drive(1'b1, 2'b00, 6'd0, 1'b1); cyc("op00");
    drive(1'b1, 2'b01, 6'd0, 1'b1); cyc("op01");
    drive(1'b1, 2'b11, 6'd0, 1'b1); cyc("op11");
    // R-type table, no bubbles
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b10, rtab[i], 1'b1); cyc("rtype");
    end
    drive(1'b0, 2'b00, 6'd0, 1'b1); cyc("drain");
    cyc("idle");

    // balrz; an offered op during beat 1 must be ignored
    drive(1'b1, 2'b10, 6'd22, 1'b1); cyc("balrz.acc");
    drive(1'b1, 2'b01, 6'd0, 1'b1); cyc("balrz.b1");
    drive(1'b0, 2'b00, 6'd0, 1'b1); cyc("balrz.b2");
    cyc("balrz.end");

    // stall three cycles in HOLD, then release with a new op
    drive(1'b1, 2'b10, 6'd42, 1'b1); cyc("stall.acc");
    drive(1'b1, 2'b10, 6'd36, 1'b0);
    repeat (3) cyc("stall.hold");
    drive(1'b1, 2'b10, 6'd36, 1'b1); cyc("stall.rel");
    drive(1'b0, 2'b00, 6'd0, 1'b1); cyc("stall.drain");

    // illegal funct 2^CW+2 times: counter saturates
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      drive(1'b1, 2'b10, 6'b111111, 1'b1); cyc("illegal");
    end
    drive(1'b0, 2'b00, 6'd0, 1'b1); cyc("illegal.drain");
    chk("illegal.sat", 32'(bus.illegal_cnt), 32'd3);

    // reset during beat 1 of balrz abandons the sequence
    drive(1'b1, 2'b10, 6'd22, 1'b0); cyc("rstmid.acc");
    drive(1'b0, 2'b00, 6'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid.link", 32'(bus.balrz_link), 32'd0);
    chk("rstmid.cnt", 32'(bus.illegal_cnt), 32'd0);
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 1'b1);
    repeat (3) cyc("rstmid.after");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rtab[$urandom_range(0, 6)];
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), f,
            1'($urandom_range(0, 3) != 0));
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
